// File: rtl/perf_sample_sequencer.sv
// rtl/perf_sample_sequencer.sv - perf counter snapshot and beat streamer
//
// Captures all counters in one cycle and streams them out one word per beat.
// A sample is requested by a manual trigger or by the periodic tick.
// Each beat carries either the absolute snapshot value or the delta against
// the value sent for that counter in the previous sample.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        sampler enable; while low, trigger and tick are ignored
//   period        auto-sample interval in cycles; 0 selects manual only
//   trigger       one-cycle manual sample request
//   counters_in   flattened live counters; ctr i at [i*CTR_BITS +: CTR_BITS]
//   out_valid/out_ready/out_data/out_idx/out_last  beat stream
//   out_seq       sequence number of the current stream
//   busy          a stream is in progress
//   missed_count  requests dropped while busy, saturating
module perf_sample_sequencer #(
    parameter int NUM_CTRS    = 16,
    parameter int CTR_BITS    = 44,
    parameter int PERIOD_BITS = 16,
    parameter int DELTA_MODE  = 1,
    localparam int IDX_BITS   = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [PERIOD_BITS-1:0]       period,
    input  logic                         trigger,
    input  logic [NUM_CTRS*CTR_BITS-1:0] counters_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTR_BITS-1:0]          out_data,
    output logic [IDX_BITS-1:0]          out_idx,
    output logic                         out_last,
    output logic [15:0]                  out_seq,
    output logic                         busy,
    output logic [15:0]                  missed_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CTRS - 1);

    state_t                 state_q, state_d;
    logic [PERIOD_BITS-1:0] timer_q, timer_d;
    logic [IDX_BITS-1:0]    idx_q, idx_d;
    logic [15:0]            seq_q, seq_d;
    logic [15:0]            missed_q, missed_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [CTR_BITS-1:0]    data_q, data_d;
    logic [CTR_BITS-1:0]    snap_q [NUM_CTRS];
    logic [CTR_BITS-1:0]    snap_d [NUM_CTRS];
    logic [CTR_BITS-1:0]    prev_q [NUM_CTRS];
    logic [CTR_BITS-1:0]    prev_d [NUM_CTRS];

    logic                   tick;
    logic                   req;
    logic                   handshake;
    logic [IDX_BITS-1:0]    idx_nxt;

    // Value carried by a beat; the subtract wraps modulo 2^CTR_BITS.
    function automatic logic [CTR_BITS-1:0] beat_value(input logic [CTR_BITS-1:0] s,
                                                       input logic [CTR_BITS-1:0] p);
        return (DELTA_MODE != 0) ? (s - p) : s;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        missed_d  = missed_q;
        valid_d   = valid_q;
        last_d    = last_q;
        data_d    = data_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        tick      = 1'b0;
        idx_nxt   = idx_q + 1'b1;
        handshake = valid_q && out_ready;

        // The >= compare lets a period lowered below the running count
        // still terminate on the next cycle instead of wrapping the timer.
        if (enable && (period != '0)) begin
            if (timer_q >= (period - PERIOD_BITS'(1))) begin
                tick    = 1'b1;
                timer_d = '0;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end else begin
            timer_d = '0;
        end

        req = enable && (trigger || tick);

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    for (int i = 0; i < NUM_CTRS; i++) begin
                        snap_d[i] = counters_in[i*CTR_BITS +: CTR_BITS];
                    end
                    idx_d   = '0;
                    state_d = ST_STREAM;
                    valid_d = 1'b1;
                    last_d  = (LAST_IDX == '0);
                    // Beat 0 is formed straight from the live input because
                    // the snapshot register is only loaded at this same edge.
                    data_d  = beat_value(counters_in[0 +: CTR_BITS], prev_q[0]);
                end
            end
            ST_STREAM: begin
                // Any request during a stream is lost, including one that
                // coincides with the final handshake.
                if (req && (missed_q != 16'hFFFF)) begin
                    missed_d = missed_q + 16'd1;
                end
                if (handshake) begin
                    prev_d[idx_q] = snap_q[idx_q];
                    if (last_q) begin
                        seq_d   = seq_q + 16'd1;
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = '0;
                        idx_d   = '0;
                    end else begin
                        idx_d  = idx_nxt;
                        last_d = (idx_nxt == LAST_IDX);
                        data_d = beat_value(snap_q[idx_nxt], prev_q[idx_nxt]);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            seq_q    <= '0;
            missed_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            for (int i = 0; i < NUM_CTRS; i++) begin
                snap_q[i] <= '0;
                prev_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            seq_q    <= seq_d;
            missed_q <= missed_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
            for (int i = 0; i < NUM_CTRS; i++) begin
                snap_q[i] <= snap_d[i];
                prev_q[i] <= prev_d[i];
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_idx      = idx_q;
    assign out_last     = last_q;
    assign out_seq      = seq_q;
    assign busy         = (state_q == ST_STREAM);
    assign missed_count = missed_q;

endmodule

// File: tb/tb_perf_sample_sequencer.sv
// tb/tb_perf_sample_sequencer.sv - self-checking bench for perf_sample_sequencer
module tb_perf_sample_sequencer;

    localparam int NUM_CTRS = 16;
    localparam int CB       = 44;
    localparam int PB       = 16;
    localparam int IW       = 4;

    logic               clk = 1'b0;
    logic               drv_reset = 1'b1;
    logic               drv_enable = 1'b0;
    logic [PB-1:0]      drv_period = '0;
    logic               drv_trigger = 1'b0;
    logic [NUM_CTRS*CB-1:0] drv_ctr = '0;
    logic               drv_ready = 1'b0;

    logic               out_valid;
    logic [CB-1:0]      out_data;
    logic [IW-1:0]      out_idx;
    logic               out_last;
    logic [15:0]        out_seq;
    logic               busy;
    logic [15:0]        missed_count;

    int n_cmp = 0;
    int n_err = 0;

    perf_sample_sequencer #(
        .NUM_CTRS(NUM_CTRS), .CTR_BITS(CB), .PERIOD_BITS(PB), .DELTA_MODE(1)
    ) dut (
        .clk(clk), .reset(drv_reset), .enable(drv_enable), .period(drv_period),
        .trigger(drv_trigger), .counters_in(drv_ctr), .out_valid(out_valid),
        .out_ready(drv_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_seq(out_seq), .busy(busy), .missed_count(missed_count)
    );

    always #5 clk = ~clk;

    // Reference model: a sample is a queue of pending beat values; the
    // delta for each counter is taken against what the last sample sent.
    logic [CB-1:0] m_q[$];
    logic [CB-1:0] m_prev [NUM_CTRS];
    logic [15:0]   m_seq = '0;
    logic [15:0]   m_missed = '0;
    int            m_since = 0;

    function automatic logic [33:0] exp_ctl();
        return {m_q.size() != 0, m_q.size() != 0, m_seq, m_missed};
    endfunction

    function automatic logic [CB+IW:0] exp_beat();
        return {m_q[0], IW'(NUM_CTRS - m_q.size()), m_q.size() == 1};
    endfunction

    // Predicts the effect of the coming rising edge with the inputs now driven.
    task automatic model_step();
        bit tick, req, was_busy;
        logic [CB-1:0] v;
        if (drv_reset) begin
            m_q.delete();
            for (int i = 0; i < NUM_CTRS; i++) m_prev[i] = '0;
            m_seq = '0; m_missed = '0; m_since = 0;
        end else begin
            tick = 1'b0;
            if (drv_enable && drv_period != 0) begin
                if (m_since + 1 >= int'(drv_period)) begin tick = 1'b1; m_since = 0; end
                else m_since = m_since + 1;
            end else m_since = 0;
            req = drv_enable && (drv_trigger || tick);
            was_busy = (m_q.size() != 0);
            if (was_busy && drv_ready) begin
                if (m_q.size() == 1) m_seq = m_seq + 16'd1;
                void'(m_q.pop_front());
            end
            if (req && was_busy) begin
                if (m_missed != 16'hFFFF) m_missed = m_missed + 16'd1;
            end else if (req) begin
                for (int i = 0; i < NUM_CTRS; i++) begin
                    v = drv_ctr[i*CB +: CB];
                    m_q.push_back(v - m_prev[i]);
                    m_prev[i] = v;
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        drv_reset = 1'b1;
        repeat (3) cycle();
        n_cmp++;
        if ({out_valid, busy, out_last, out_data, out_seq, missed_count} !== '0) begin
            n_err++;
            $display("FAIL reset: valid=%b busy=%b last=%b data=%h seq=%0d missed=%0d exp all 0",
                     out_valid, busy, out_last, out_data, out_seq, missed_count);
        end
        drv_reset = 1'b0;
    endtask

    task automatic test_absolute();
        for (int i = 0; i < NUM_CTRS; i++) drv_ctr[i*CB +: CB] = CB'(i * 10);
        drv_enable = 1'b1; drv_period = '0; drv_ready = 1'b1; drv_trigger = 1'b1;
        cycle();
        drv_trigger = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL abs_latency: out_valid=%b exp 1", out_valid);
        end
        for (int i = 0; i < NUM_CTRS; i++) begin
            n_cmp++;
            if ({out_data, out_idx, out_last, out_seq} !== {CB'(i * 10), IW'(i), i == NUM_CTRS - 1, 16'd0}) begin
                n_err++;
                $display("FAIL abs_beat%0d: data=%0d idx=%0d last=%b seq=%0d exp %0d/%0d/%b/0",
                         i, out_data, out_idx, out_last, out_seq, i * 10, i, i == NUM_CTRS - 1);
            end
            cycle();
        end
        n_cmp++;
        if ({out_valid, out_seq} !== {1'b0, 16'd1}) begin
            n_err++; $display("FAIL abs_done: valid=%b seq=%0d exp 0/1", out_valid, out_seq);
        end
    endtask

    task automatic test_delta();
        for (int i = 0; i < NUM_CTRS; i++) drv_ctr[i*CB +: CB] = CB'(i * 10 + 5);
        drv_trigger = 1'b1;
        cycle();
        drv_trigger = 1'b0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            n_cmp++;
            if ({out_valid, out_data, out_idx, out_seq} !== {1'b1, CB'(5), IW'(i), 16'd1}) begin
                n_err++;
                $display("FAIL delta_beat%0d: valid=%b data=%0d idx=%0d seq=%0d exp 1/5/%0d/1",
                         i, out_valid, out_data, out_idx, out_seq, i);
            end
            n_cmp++;
            if ({out_valid, busy, out_seq, missed_count} !== exp_ctl()) begin
                n_err++; $display("FAIL delta_ctl: got %h exp %h",
                                  {out_valid, busy, out_seq, missed_count}, exp_ctl());
            end
            cycle();
        end
    endtask

    task automatic test_wrap_stall();
        logic [CB-1:0] hold_data;
        logic [IW-1:0] hold_idx;
        bit            stalled;
        int            beats;
        logic [15:0]   seq0;
        logic [CB-1:0] big;
        big = '1;
        drv_ctr[0 +: CB] = big - CB'(2);
        drv_trigger = 1'b1;
        cycle();
        drv_trigger = 1'b0;
        repeat (NUM_CTRS) cycle();
        drv_ctr[0 +: CB] = CB'(2);
        drv_trigger = 1'b1;
        drv_ready = 1'b0;
        cycle();
        drv_trigger = 1'b0;
        n_cmp++;
        if ({out_valid, out_idx, out_data} !== {1'b1, IW'(0), CB'(5)}) begin
            n_err++; $display("FAIL wrap_ctr0: valid=%b idx=%0d data=%h exp 1/0/5",
                              out_valid, out_idx, out_data);
        end
        seq0 = m_seq; beats = 0; stalled = 1'b0;
        for (int k = 0; k < 200 && m_seq == seq0; k++) begin
            if (stalled) begin
                n_cmp++;
                if ({out_data, out_idx} !== {hold_data, hold_idx}) begin
                    n_err++; $display("FAIL stall_hold: data=%h idx=%0d exp %h/%0d",
                                      out_data, out_idx, hold_data, hold_idx);
                end
            end
            if (m_q.size() != 0) begin
                n_cmp++;
                if ({out_data, out_idx, out_last} !== exp_beat()) begin
                    n_err++; $display("FAIL stall_beat: got %h exp %h",
                                      {out_data, out_idx, out_last}, exp_beat());
                end
            end
            drv_ready = ($urandom_range(0, 1) == 1);
            stalled = out_valid && !drv_ready;
            hold_data = out_data; hold_idx = out_idx;
            if (out_valid && drv_ready) beats++;
            cycle();
        end
        n_cmp++;
        if ({beats, out_valid, out_seq} !== {32'(NUM_CTRS), 1'b0, seq0 + 16'd1}) begin
            n_err++; $display("FAIL stall_count: beats=%0d valid=%b seq=%0d exp %0d/0/%0d",
                              beats, out_valid, out_seq, NUM_CTRS, seq0 + 16'd1);
        end
        drv_ready = 1'b1;
    endtask

    task automatic test_period100();
        int rises[$];
        logic pv;
        drv_enable = 1'b0; cycle();
        drv_period = 16'd100; drv_enable = 1'b1;
        pv = out_valid;
        for (int k = 1; k <= 250; k++) begin
            cycle();
            if (out_valid && !pv) rises.push_back(k);
            pv = out_valid;
            n_cmp++;
            if ({out_valid, busy, out_seq, missed_count} !== exp_ctl()) begin
                n_err++; $display("FAIL per100_ctl k=%0d: got %h exp %h", k,
                                  {out_valid, busy, out_seq, missed_count}, exp_ctl());
            end
        end
        n_cmp++;
        if (rises.size() != 2 || rises[0] != 100 || rises[1] != 200 || missed_count !== 16'd0) begin
            n_err++; $display("FAIL per100_timing: rises=%0d first=%0d second=%0d missed=%0d exp 2/100/200/0",
                              rises.size(), rises.size() > 0 ? rises[0] : -1,
                              rises.size() > 1 ? rises[1] : -1, missed_count);
        end
        drv_enable = 1'b0; drv_period = '0;
        repeat (20) cycle();
    endtask

    task automatic test_drops();
        drv_period = 16'd10; drv_enable = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            drv_ctr[3*CB +: CB] = drv_ctr[3*CB +: CB] + CB'($urandom_range(0, 9));
            cycle();
            n_cmp++;
            if ({out_valid, busy, out_seq, missed_count} !== exp_ctl()) begin
                n_err++; $display("FAIL drops_ctl k=%0d: got %h exp %h", k,
                                  {out_valid, busy, out_seq, missed_count}, exp_ctl());
            end
            if (m_q.size() != 0) begin
                n_cmp++;
                if ({out_data, out_idx, out_last} !== exp_beat()) begin
                    n_err++; $display("FAIL drops_beat k=%0d: got %h exp %h", k,
                                      {out_data, out_idx, out_last}, exp_beat());
                end
            end
        end
        n_cmp++;
        if (missed_count !== 16'd3) begin
            n_err++; $display("FAIL drops_count: missed=%0d exp 3", missed_count);
        end
        drv_enable = 1'b0; drv_period = '0;
        repeat (20) cycle();
    endtask

    task automatic test_saturate();
        drv_enable = 1'b1; drv_ready = 1'b0; drv_trigger = 1'b1;
        repeat (70000) cycle();
        n_cmp++;
        if ({missed_count, busy} !== {16'hFFFF, 1'b1} || exp_ctl() !== {out_valid, busy, out_seq, missed_count}) begin
            n_err++; $display("FAIL saturate: missed=%h busy=%b exp ffff/1", missed_count, busy);
        end
        drv_trigger = 1'b0; drv_ready = 1'b1;
        repeat (20) cycle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NUM_CTRS; i++) drv_ctr[i*CB +: CB] = {12'($urandom), $urandom};
        drv_trigger = 1'b1; cycle(); drv_trigger = 1'b0;
        repeat (7) cycle();
        n_cmp++;
        if ({out_valid, out_idx} !== {1'b1, IW'(7)}) begin
            n_err++; $display("FAIL rst_mid_pos: valid=%b idx=%0d exp 1/7", out_valid, out_idx);
        end
        drv_reset = 1'b1; cycle(); drv_reset = 1'b0;
        n_cmp++;
        if ({out_valid, busy, out_seq, missed_count} !== 34'd0) begin
            n_err++; $display("FAIL rst_mid_state: valid=%b busy=%b seq=%0d missed=%0d exp 0",
                              out_valid, busy, out_seq, missed_count);
        end
        for (int i = 0; i < NUM_CTRS; i++) drv_ctr[i*CB +: CB] = {12'($urandom), $urandom};
        drv_trigger = 1'b1; cycle(); drv_trigger = 1'b0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            n_cmp++;
            if ({out_valid, out_idx, out_data} !== {1'b1, IW'(i), drv_ctr[i*CB +: CB]}) begin
                n_err++; $display("FAIL rst_abs_beat%0d: valid=%b idx=%0d data=%h exp 1/%0d/%h",
                                  i, out_valid, out_idx, out_data, i, drv_ctr[i*CB +: CB]);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0)
                drv_period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            drv_reset   = ($urandom_range(0, 299) == 0);
            drv_enable  = ($urandom_range(0, 9) != 0);
            drv_trigger = ($urandom_range(0, 19) == 0);
            drv_ready   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_CTRS; i++)
                drv_ctr[i*CB +: CB] = drv_ctr[i*CB +: CB] + CB'($urandom_range(0, 3));
            cycle();
            n_cmp++;
            if ({out_valid, busy, out_seq, missed_count} !== exp_ctl()) begin
                n_err++; $display("FAIL rand_ctl k=%0d: got %h exp %h", k,
                                  {out_valid, busy, out_seq, missed_count}, exp_ctl());
            end
            if (m_q.size() != 0) begin
                n_cmp++;
                if ({out_data, out_idx, out_last} !== exp_beat()) begin
                    n_err++; $display("FAIL rand_beat k=%0d: got %h exp %h", k,
                                      {out_data, out_idx, out_last}, exp_beat());
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CTRS; i++) m_prev[i] = '0;
        test_reset();
        test_absolute();
        test_delta();
        test_wrap_stall();
        test_period100();
        test_drops();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
